proj_extender_stream: RTL

//  Streaming successor to the fixed-timing extender. Accepts one fragment plus up to INDICES_COUNT
//  k-mer indices through a valid/ready handshake. For every valid index it emits all fragment parts,
//  one part per beat: one-hot encoded bases (GFM) tagged with the index re-centred by the k-mer offset.

---
 rtl/proj_extender_stream.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/proj_extender_stream.sv
`default_nettype none
// ============================================================================
// Module      : proj_extender_stream
// Description : Streams one-hot (GFM) fragment parts per k-mer index, with
//               re-centred index, over a valid/ready handshake.
//               Optional reverse-complement mode: PROJ_EXTENDER_REVCOMP_EN
// Revision    : 1.0 - initial release
// ============================================================================
module proj_extender_stream #(
    parameter int FRAG_LEN      = 64,
    parameter int KMER_LEN      = 16,
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 6,
    parameter int PART_BASES    = 16,
    parameter int BASE_LEN      = 2,
    parameter int ONE_HOT_LEN   = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [FRAG_LEN*BASE_LEN-1:0]              in_fragment,
    input  logic [INDICES_COUNT*INDICE_LEN-1:0]       in_kmer_indices,
    input  logic [$clog2(INDICES_COUNT+1)-1:0]        in_count,
`ifdef PROJ_EXTENDER_REVCOMP_EN
    input  logic                                      in_revcomp,
`endif
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [INDICE_LEN:0]                       out_index,
    output logic [((FRAG_LEN/PART_BASES) > 1 ? $clog2(FRAG_LEN/PART_BASES) : 1)-1:0] out_part_idx,
    output logic                                      out_last_part,
    output logic                                      out_last,
    output logic [PART_BASES*ONE_HOT_LEN-1:0]         out_gfm
);

    localparam int C_OFFSET    = (FRAG_LEN - KMER_LEN) >> 1;
    localparam int C_PARTS     = FRAG_LEN / PART_BASES;
    localparam int C_PART_W    = (C_PARTS > 1) ? $clog2(C_PARTS) : 1;
    localparam int C_PART_BITS = PART_BASES * BASE_LEN;
    localparam int C_CNT_W     = $clog2(INDICES_COUNT + 1);
    localparam int C_IDX_W     = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                              r_state, w_state_next;
    logic [C_PART_W-1:0]                 r_part, w_part_next;
    logic [C_IDX_W-1:0]                  r_idx, w_idx_next;

    logic [FRAG_LEN*BASE_LEN-1:0]        r_frag;
    logic [INDICES_COUNT*INDICE_LEN-1:0] r_indices;
    logic [C_CNT_W-1:0]                  r_count;
    logic                                w_rev;

    logic                                w_accept;
    logic                                w_beat;
    logic                                w_last_part;
    logic                                w_last;
    logic [C_CNT_W-1:0]                  w_count_clamped;
    logic [C_PART_W-1:0]                 w_src_part;
    logic [C_PART_BITS-1:0]              w_part_bits;
    logic [BASE_LEN-1:0]                 w_code;
    logic [PART_BASES*ONE_HOT_LEN-1:0]   w_gfm;
    logic [INDICE_LEN-1:0]               w_sel_idx;
    logic [INDICE_LEN:0]                 w_index;

    assign w_count_clamped = (in_count > C_CNT_W'(INDICES_COUNT)) ? C_CNT_W'(INDICES_COUNT) : in_count;
    assign w_accept        = (r_state == S_IDLE) && in_valid;
    assign w_beat          = (r_state == S_STREAM) && out_ready;
    assign w_last_part     = (r_part == C_PART_W'(C_PARTS - 1));
    assign w_last          = w_last_part && (C_CNT_W'(r_idx) == (r_count - C_CNT_W'(1)));

`ifdef PROJ_EXTENDER_REVCOMP_EN
    logic r_revcomp;
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_revcomp <= in_revcomp;
        end
    end
    assign w_rev = r_revcomp;
`else
    assign w_rev = 1'b0;
`endif

    // Captured transaction data; intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_frag    <= in_fragment;
            r_indices <= in_kmer_indices;
            r_count   <= w_count_clamped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_part  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_part  <= w_part_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_part_next  = r_part;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE: begin
                w_part_next = '0;
                w_idx_next  = '0;
                // A zero-count transaction is consumed without producing beats.
                if (w_accept && (w_count_clamped != '0)) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_beat) begin
                    if (w_last_part) begin
                        w_part_next = '0;
                        if (w_last) begin
                            w_idx_next   = '0;
                            w_state_next = S_IDLE;
                        end else begin
                            w_idx_next = r_idx + C_IDX_W'(1);
                        end
                    end else begin
                        w_part_next = r_part + C_PART_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Reverse-complement walks parts and bases backwards and inverts each code.
    assign w_src_part  = w_rev ? (C_PART_W'(C_PARTS - 1) - r_part) : r_part;
    assign w_part_bits = r_frag[w_src_part*C_PART_BITS +: C_PART_BITS];

    always_comb begin
        w_gfm  = '0;
        w_code = '0;
        for (int i = 0; i < PART_BASES; i++) begin
            if (w_rev) begin
                w_code = ~w_part_bits[(PART_BASES-1-i)*BASE_LEN +: BASE_LEN];
            end else begin
                w_code = w_part_bits[i*BASE_LEN +: BASE_LEN];
            end
            w_gfm[i*ONE_HOT_LEN +: ONE_HOT_LEN] = ONE_HOT_LEN'(1) << w_code;
        end
    end

    assign w_sel_idx = r_indices[r_idx*INDICE_LEN +: INDICE_LEN];
    assign w_index   = {1'b0, w_sel_idx} - (INDICE_LEN+1)'(C_OFFSET);

    assign in_ready      = (r_state == S_IDLE);
    assign out_valid     = (r_state == S_STREAM);
    assign out_index     = out_valid ? w_index : '0;
    assign out_part_idx  = out_valid ? r_part : '0;
    assign out_last_part = out_valid && w_last_part;
    assign out_last      = out_valid && w_last;
    assign out_gfm       = out_valid ? w_gfm : '0;

endmodule
`default_nettype wire
